// File: rtl/io_bus_arbiter_if.sv
// Requester and io-bus signals of io_bus_arbiter. The master modport is the
// arbiter's view; slave is the view of the requesters and the bus around it.
interface io_bus_arbiter_if #(
  parameter int XLEN       = 32,
  parameter int LINE_BYTES = 16
);
  logic                    line_req;
  logic                    line_we;
  logic [XLEN-1:0]         line_addr;
  logic [LINE_BYTES*8-1:0] line_wdata;
  logic [LINE_BYTES*8-1:0] line_rdata;
  logic                    line_ready;
  logic                    line_busy;

  logic                    per_req;
  logic                    per_we;
  logic [XLEN-1:0]         per_addr;
  logic [XLEN-1:0]         per_wdata;
  logic [1:0]              per_byte_size;
  logic [XLEN-1:0]         per_rdata;
  logic                    per_ready;

  logic [XLEN-1:0]         io_addr;
  logic                    io_read;
  logic                    io_write;
  logic [XLEN-1:0]         io_wdata;
  logic [1:0]              io_byte_size;
  logic                    burst;
  logic [2:0]              burst_size;
  logic [XLEN-1:0]         io_rdata;
  logic                    io_ready;

  modport master (
    input  line_req, line_we, line_addr, line_wdata,
    output line_rdata, line_ready, line_busy,
    input  per_req, per_we, per_addr, per_wdata, per_byte_size,
    output per_rdata, per_ready,
    output io_addr, io_read, io_write, io_wdata, io_byte_size, burst, burst_size,
    input  io_rdata, io_ready
  );

  modport slave (
    output line_req, line_we, line_addr, line_wdata,
    input  line_rdata, line_ready, line_busy,
    output per_req, per_we, per_addr, per_wdata, per_byte_size,
    input  per_rdata, per_ready,
    input  io_addr, io_read, io_write, io_wdata, io_byte_size, burst, burst_size,
    output io_rdata, io_ready
  );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin owner of the external io bus: word-by-word cache-line bursts on
// one side, single peripheral accesses on the other, one idle cycle in between.
module io_bus_arbiter #(
  parameter int XLEN       = 32,
  parameter int LINE_BYTES = 16
) (
  input  logic             clk,
  input  logic             rst,
  io_bus_arbiter_if.master bus
);
  localparam int              WORDS      = LINE_BYTES / (XLEN / 8);
  localparam int              LW         = LINE_BYTES * 8;
  localparam int              CNT_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(WORDS - 1);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(LINE_BYTES - 1);
  localparam logic [XLEN-1:0] WORD_STEP  = XLEN'(XLEN / 8);

  typedef enum logic [1:0] {S_IDLE, S_LINE, S_PER, S_DONE} state_t;
  typedef enum logic {GRANT_LINE, GRANT_PER} grant_t;

  state_t           state_q, state_d;
  grant_t           last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  io_addr_q, io_addr_d;
  logic [XLEN-1:0]  io_wdata_q, io_wdata_d;
  logic             io_read_q, io_read_d;
  logic             io_write_q, io_write_d;
  logic [1:0]       io_byte_size_q, io_byte_size_d;
  logic             burst_q, burst_d;
  logic [2:0]       burst_size_q, burst_size_d;
  logic             line_busy_q, line_busy_d;
  logic             line_ready_q, line_ready_d;
  logic             per_ready_q, per_ready_d;
  logic [LW-1:0]    line_buf_q, line_buf_d;
  logic [LW-1:0]    line_rdata_q, line_rdata_d;
  logic [XLEN-1:0]  per_rdata_q, per_rdata_d;
  logic             grant_line, grant_per;

  // On a tie the channel that did not win last time gets the bus.
  assign grant_line = bus.line_req && (!bus.per_req || last_grant_q == GRANT_PER);
  assign grant_per  = bus.per_req && !grant_line;

  always_comb begin
    // NOTE: every _d gets a default before the case so no latch is inferred.
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    cnt_d          = cnt_q;
    io_addr_d      = io_addr_q;
    io_wdata_d     = io_wdata_q;
    io_read_d      = io_read_q;
    io_write_d     = io_write_q;
    io_byte_size_d = io_byte_size_q;
    burst_d        = burst_q;
    burst_size_d   = burst_size_q;
    line_busy_d    = line_busy_q;
    line_ready_d   = 1'b0;
    per_ready_d    = 1'b0;
    line_buf_d     = line_buf_q;
    line_rdata_d   = line_rdata_q;
    per_rdata_d    = per_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (grant_line) begin
          state_d        = S_LINE;
          last_grant_d   = GRANT_LINE;
          cnt_d          = '0;
          io_addr_d      = bus.line_addr & ALIGN_MASK;
          io_wdata_d     = bus.line_wdata[XLEN-1:0];
          io_read_d      = !bus.line_we;
          io_write_d     = bus.line_we;
          io_byte_size_d = 2'd0;
          burst_d        = 1'b1;
          burst_size_d   = 3'(WORDS - 1);
          line_busy_d    = 1'b1;
        end else if (grant_per) begin
          state_d        = S_PER;
          last_grant_d   = GRANT_PER;
          io_addr_d      = bus.per_addr;
          io_wdata_d     = bus.per_wdata;
          io_read_d      = !bus.per_we;
          io_write_d     = bus.per_we;
          io_byte_size_d = bus.per_byte_size;
          burst_d        = 1'b0;
          burst_size_d   = 3'd0;
        end
      end

      S_LINE: begin
        if (bus.io_ready) begin
          if (!io_write_q) line_buf_d[int'(cnt_q) * XLEN +: XLEN] = bus.io_rdata;
          if (cnt_q == LAST_CNT) begin
            // The line becomes visible only once every word has arrived.
            if (!io_write_q) line_rdata_d = line_buf_d;
            state_d      = S_DONE;
            io_read_d    = 1'b0;
            io_write_d   = 1'b0;
            burst_d      = 1'b0;
            burst_size_d = 3'd0;
            line_busy_d  = 1'b0;
            line_ready_d = 1'b1;
          end else begin
            cnt_d      = cnt_q + CNT_W'(1);
            io_addr_d  = io_addr_q + WORD_STEP;
            io_wdata_d = bus.line_wdata[(int'(cnt_q) + 1) * XLEN +: XLEN];
          end
        end
      end

      S_PER: begin
        if (bus.io_ready) begin
          if (!io_write_q) per_rdata_d = bus.io_rdata;
          state_d     = S_DONE;
          io_read_d   = 1'b0;
          io_write_d  = 1'b0;
          per_ready_d = 1'b1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      last_grant_q   <= GRANT_PER;
      cnt_q          <= '0;
      io_addr_q      <= '0;
      io_wdata_q     <= '0;
      io_read_q      <= 1'b0;
      io_write_q     <= 1'b0;
      io_byte_size_q <= 2'd0;
      burst_q        <= 1'b0;
      burst_size_q   <= 3'd0;
      line_busy_q    <= 1'b0;
      line_ready_q   <= 1'b0;
      per_ready_q    <= 1'b0;
      // NOTE: the assembly buffer is reset as well, so a refill never exposes
      // words left over from an aborted burst or power-up X.
      line_buf_q     <= '0;
      line_rdata_q   <= '0;
      per_rdata_q    <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      cnt_q          <= cnt_d;
      io_addr_q      <= io_addr_d;
      io_wdata_q     <= io_wdata_d;
      io_read_q      <= io_read_d;
      io_write_q     <= io_write_d;
      io_byte_size_q <= io_byte_size_d;
      burst_q        <= burst_d;
      burst_size_q   <= burst_size_d;
      line_busy_q    <= line_busy_d;
      line_ready_q   <= line_ready_d;
      per_ready_q    <= per_ready_d;
      line_buf_q     <= line_buf_d;
      line_rdata_q   <= line_rdata_d;
      per_rdata_q    <= per_rdata_d;
    end
  end

  assign bus.io_addr      = io_addr_q;
  assign bus.io_wdata     = io_wdata_q;
  assign bus.io_read      = io_read_q;
  assign bus.io_write     = io_write_q;
  assign bus.io_byte_size = io_byte_size_q;
  assign bus.burst        = burst_q;
  assign bus.burst_size   = burst_size_q;
  assign bus.line_busy    = line_busy_q;
  assign bus.line_ready   = line_ready_q;
  assign bus.per_ready    = per_ready_q;
  assign bus.line_rdata   = line_rdata_q;
  assign bus.per_rdata    = per_rdata_q;
endmodule
